// File: rtl/water_dispatch_scheduler.sv
// Reservoir dispatch scheduler: round-robin city/town draw arbitration,
// demand calculation, rain inflow and saturating level bookkeeping.
module water_dispatch_scheduler #(
  parameter int MAX_RESERVOIR = 1000,
  parameter int INIT_LEVEL    = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       city_req,
  input  logic       town_req,
  input  logic [8:0] city_pop,
  input  logic [8:0] town_pop,
  input  logic       rain_valid,
  input  logic [5:0] rain_amount,
  output logic       city_grant,
  output logic       town_grant,
  output logic [9:0] grant_amount,
  output logic       shortage,
  output logic       overflow,
  output logic       busy,
  output logic [9:0] reservoir_level
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CALC     = 2'd1,
    S_DISPATCH = 2'd2
  } state_t;

  localparam logic [10:0] LP_MAX  = 11'(MAX_RESERVOIR);
  localparam logic [9:0]  LP_INIT = 10'(INIT_LEVEL);

  state_t      r_state;
  logic        r_win_town;
  logic        r_last_town;
  logic [8:0]  r_pop;
  logic [9:0]  r_demand;

  logic [10:0] w_rain;
  logic [10:0] w_sum;
  logic        w_over;
  logic [9:0]  w_avail;
  logic        w_short;
  logic [9:0]  w_give;
  logic [12:0] w_prod;
  logic [9:0]  w_demand;
  logic        w_pick_town;
  logic        w_any_req;

  // Rain is always folded in first, so the dispatch sees the topped-up level
  assign w_rain   = rain_valid ? {5'd0, rain_amount} : 11'd0;
  assign w_sum    = {1'b0, reservoir_level} + w_rain;
  assign w_over   = w_sum > LP_MAX;
  assign w_avail  = w_over ? LP_MAX[9:0] : w_sum[9:0];
  assign w_short  = r_demand > w_avail;
  assign w_give   = w_short ? w_avail : r_demand;

  assign w_prod   = 13'(r_pop) * 13'd9;
  assign w_demand = 10'(w_prod >> 3);

  assign w_any_req   = city_req | town_req;
  assign w_pick_town = town_req & (~city_req | ~r_last_town);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_win_town      <= 1'b0;
      r_last_town     <= 1'b1;
      r_pop           <= '0;
      r_demand        <= '0;
      city_grant      <= 1'b0;
      town_grant      <= 1'b0;
      grant_amount    <= '0;
      shortage        <= 1'b0;
      overflow        <= 1'b0;
      busy            <= 1'b0;
      reservoir_level <= LP_INIT;
    end else begin
      city_grant      <= 1'b0;
      town_grant      <= 1'b0;
      grant_amount    <= '0;
      shortage        <= 1'b0;
      overflow        <= w_over;
      reservoir_level <= w_avail;
      unique case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_win_town <= w_pick_town;
            r_pop      <= w_pick_town ? town_pop : city_pop;
            r_state    <= S_CALC;
            busy       <= 1'b1;
          end
        end
        S_CALC: begin
          r_demand <= w_demand;
          r_state  <= S_DISPATCH;
          busy     <= 1'b1;
        end
        S_DISPATCH: begin
          city_grant      <= ~r_win_town;
          town_grant      <= r_win_town;
          grant_amount    <= w_give;
          shortage        <= w_short;
          r_last_town     <= r_win_town;
          reservoir_level <= w_avail - w_give;
          r_state         <= S_IDLE;
          busy            <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_water_dispatch_scheduler.sv
// Bench for water_dispatch_scheduler: vector table, corner sequences
// and randomized transactions against a transaction-level model.
`timescale 1ns/1ps
module tb_water_dispatch_scheduler;

  localparam int MAXR = 1000;
  localparam int INIT = 500;

  logic       clk = 1'b0;
  logic       reset;
  logic       city_req, town_req, rain_valid;
  logic [8:0] city_pop, town_pop;
  logic [5:0] rain_amount;
  logic       city_grant, town_grant, shortage, overflow, busy;
  logic [9:0] grant_amount, reservoir_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  water_dispatch_scheduler #(
    .MAX_RESERVOIR(MAXR),
    .INIT_LEVEL(INIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .city_req(city_req),
    .town_req(town_req),
    .city_pop(city_pop),
    .town_pop(town_pop),
    .rain_valid(rain_valid),
    .rain_amount(rain_amount),
    .city_grant(city_grant),
    .town_grant(town_grant),
    .grant_amount(grant_amount),
    .shortage(shortage),
    .overflow(overflow),
    .busy(busy),
    .reservoir_level(reservoir_level)
  );

  typedef struct {
    logic [8:0] cpop;
    logic [8:0] tpop;
    logic       creq;
    logic       treq;
    logic       rv;
    logic [5:0] ra;
    logic       ecity;
    logic       etown;
    logic [9:0] eamt;
    logic       eshort;
    logic [9:0] elevel;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    city_req = 0; town_req = 0; rain_valid = 0;
    rain_amount = 0; city_pop = 0; town_pop = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    city_pop = v.cpop; town_pop = v.tpop;
    city_req = v.creq; town_req = v.treq;
    rain_valid = 0;
    tick();
    chk({tag, " busy_calc"}, busy, 1);
    city_pop = ~v.cpop;
    town_pop = ~v.tpop;
    tick();
    chk({tag, " no_early_grant"}, city_grant | town_grant, 0);
    rain_valid = v.rv; rain_amount = v.ra;
    tick();
    rain_valid = 0; city_req = 0; town_req = 0;
    chk({tag, " city_grant"}, city_grant, v.ecity);
    chk({tag, " town_grant"}, town_grant, v.etown);
    chk({tag, " amount"}, grant_amount, v.eamt);
    chk({tag, " shortage"}, shortage, v.eshort);
    chk({tag, " level"}, reservoir_level, v.elevel);
    chk({tag, " busy_done"}, busy, 0);
  endtask

  task automatic rain_cycle(input logic [5:0] amt);
    rain_valid = 1; rain_amount = amt;
    tick();
    rain_valid = 0;
  endtask

  task automatic climb_to_990();
    for (int i = 0; i < 7; i++) rain_cycle(6'd63);
    rain_cycle(6'd49);
  endtask

  int mlevel, mdemand, mgive, sum, gap;
  bit mlast_city, win_city, cr, tr, rv, eov, eshort;
  int cp, tp, ra;

  initial begin
    reset = 1'b1;
    city_req = 0; town_req = 0; rain_valid = 0;
    rain_amount = 0; city_pop = 0; town_pop = 0;

    vecs[0] = '{9'd50,  9'd0,   1, 0, 0, 6'd0,  1, 0, 10'd56,  0, 10'd444};
    vecs[1] = '{9'd10,  9'd30,  1, 1, 0, 6'd0,  0, 1, 10'd33,  0, 10'd411};
    vecs[2] = '{9'd0,   9'd100, 1, 1, 0, 6'd0,  1, 0, 10'd0,   0, 10'd411};
    vecs[3] = '{9'd0,   9'd511, 0, 1, 1, 6'd10, 0, 1, 10'd421, 1, 10'd0};
    vecs[4] = '{9'd100, 9'd0,   1, 0, 1, 6'd20, 1, 0, 10'd20,  1, 10'd0};
    vecs[5] = '{9'd8,   9'd8,   1, 1, 1, 6'd63, 0, 1, 10'd9,   0, 10'd54};
    vecs[6] = '{9'd511, 9'd1,   1, 1, 0, 6'd0,  1, 0, 10'd54,  1, 10'd0};

    do_reset();
    chk("rst level", reservoir_level, INIT);
    chk("rst busy", busy, 0);
    chk("rst grants", {city_grant, town_grant}, 0);
    chk("rst amount", grant_amount, 0);
    chk("rst flags", {shortage, overflow}, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Both requests held: city first, town three cycles later
    do_reset();
    city_pop = 50; town_pop = 30; city_req = 1; town_req = 1;
    tick(); tick(); tick();
    chk("rr city_grant", city_grant, 1);
    chk("rr town_idle", town_grant, 0);
    chk("rr city_amt", grant_amount, 56);
    chk("rr lvl1", reservoir_level, 444);
    city_req = 0;
    tick();
    chk("rr gap1", city_grant | town_grant, 0);
    chk("rr gap1_amt", grant_amount, 0);
    tick();
    chk("rr gap2", city_grant | town_grant, 0);
    tick();
    town_req = 0;
    chk("rr town_grant", town_grant, 1);
    chk("rr town_amt", grant_amount, 33);
    chk("rr lvl2", reservoir_level, 411);

    // Rain coinciding with the dispatch
    do_reset();
    city_pop = 50; city_req = 1;
    tick(); tick();
    rain_valid = 1; rain_amount = 10;
    tick();
    rain_valid = 0; city_req = 0;
    chk("rain_disp amt", grant_amount, 56);
    chk("rain_disp lvl", reservoir_level, 454);

    // Request dropped after sampling still completes
    do_reset();
    city_pop = 50; city_req = 1;
    tick();
    city_req = 0;
    tick(); tick();
    chk("drop grant", city_grant, 1);
    chk("drop amt", grant_amount, 56);

    // Overflow at the ceiling, and exact fill without overflow
    do_reset();
    climb_to_990();
    chk("climb lvl", reservoir_level, 990);
    chk("climb no_ov", overflow, 0);
    rain_cycle(6'd20);
    chk("ovf lvl", reservoir_level, 1000);
    chk("ovf pulse", overflow, 1);
    tick();
    chk("ovf clear", overflow, 0);
    chk("ovf hold", reservoir_level, 1000);
    do_reset();
    climb_to_990();
    rain_cycle(6'd10);
    chk("fill lvl", reservoir_level, 1000);
    chk("fill no_ov", overflow, 0);

    // Reset while in CALC aborts the service
    do_reset();
    city_pop = 50; city_req = 1;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort busy", busy, 0);
    chk("abort lvl", reservoir_level, INIT);
    chk("abort grant", city_grant | town_grant, 0);
    @(negedge clk);
    city_req = 0;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort no_grant", city_grant | town_grant, 0);
      chk("abort lvl_hold", reservoir_level, INIT);
    end

    // Randomized transactions against the model
    do_reset();
    mlevel = INIT;
    mlast_city = 0;
    for (int t = 0; t < 60; t++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        rv = 1'($urandom_range(0, 1));
        ra = $urandom_range(0, 63);
        rain_valid = rv; rain_amount = 6'(ra);
        tick();
        sum = mlevel + (rv ? ra : 0);
        eov = sum > MAXR;
        mlevel = eov ? MAXR : sum;
        chk("rnd idle_lvl", reservoir_level, mlevel);
        chk("rnd idle_ov", overflow, eov);
        chk("rnd idle_grant", city_grant | town_grant, 0);
      end
      do begin
        cr = 1'($urandom_range(0, 1));
        tr = 1'($urandom_range(0, 1));
      end while (!cr && !tr);
      cp = $urandom_range(0, 511);
      tp = $urandom_range(0, 511);
      if (cr && tr) win_city = !mlast_city;
      else win_city = cr;
      mdemand = ((win_city ? cp : tp) * 9) / 8;
      city_req = cr; town_req = tr;
      city_pop = 9'(cp); town_pop = 9'(tp);
      for (int c = 0; c < 3; c++) begin
        rv = 1'($urandom_range(0, 1));
        ra = $urandom_range(0, 63);
        rain_valid = rv; rain_amount = 6'(ra);
        tick();
        city_pop = 9'($urandom_range(0, 511));
        town_pop = 9'($urandom_range(0, 511));
        sum = mlevel + (rv ? ra : 0);
        eov = sum > MAXR;
        mlevel = eov ? MAXR : sum;
        if (c == 2) begin
          eshort = mdemand > mlevel;
          mgive = eshort ? mlevel : mdemand;
          mlevel = mlevel - mgive;
          mlast_city = win_city;
          chk("rnd city_grant", city_grant, win_city);
          chk("rnd town_grant", town_grant, !win_city);
          chk("rnd amount", grant_amount, mgive);
          chk("rnd shortage", shortage, eshort);
          chk("rnd busy_done", busy, 0);
        end else begin
          chk("rnd busy", busy, 1);
          chk("rnd no_grant", city_grant | town_grant, 0);
        end
        chk("rnd lvl", reservoir_level, mlevel);
        chk("rnd ov", overflow, eov);
      end
      rain_valid = 0; city_req = 0; town_req = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
